// File: rtl/serial_word_collector.sv
// -----------------------------------------------------------------------------
// serial_word_collector
//
// Collects a single-bit stream (an SLE register output) into WIDTH-bit words
// and places each completed word in a one-deep VALID/READY holding register.
// The shifter accepts bits every enabled edge with no dead cycle between
// frames.
// If the holding register is still occupied and not being drained, the new
// word is dropped and a sticky overflow flag is raised.
//
// Optional feature macro: PARITY_EN
//   When defined, each frame carries one extra trailing even-parity bit
//   (frame = WIDTH+1). The parity bit is not stored in DOUT. The PERR output
//   reports a parity error for the word currently held in DOUT.
//   When undefined, frame = WIDTH and there is no parity logic and no PERR
//   port.
//
// Parameters
//   WIDTH      data bits per word, 2..32
//   MSB_FIRST  1: first sampled bit lands in DOUT[WIDTH-1]
//              0: first sampled bit lands in DOUT[0]
//
// Ports
//   CLK     in   rising-edge clock
//   RSTn    in   asynchronous active-low reset
//   SIN     in   serial data
//   EN      in   sample enable; SIN taken only on edges with EN=1
//   SCLRn   in   synchronous active-low clear; has priority over EN/READY
//   DOUT    out  completed word, stable while VALID=1
//   VALID   out  word available (registered, never depends on READY)
//   READY   in   consumer takes DOUT on an edge with VALID=1
//   OVF     out  sticky overflow; cleared only by SCLRn or RSTn
//   BITCNT  out  bits collected in the current frame
//   PERR    out  (PARITY_EN only) parity error for the held word
// -----------------------------------------------------------------------------
module serial_word_collector #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
`ifdef PARITY_EN
  localparam int unsigned FRAME    = WIDTH + 1,
`else
  localparam int unsigned FRAME    = WIDTH,
`endif
  localparam int unsigned CNT_W    = $clog2(FRAME + 1)
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             SIN,
  input  logic             EN,
  input  logic             SCLRn,
  output logic [WIDTH-1:0] DOUT,
  output logic             VALID,
  input  logic             READY,
  output logic             OVF,
  output logic [CNT_W-1:0] BITCNT
`ifdef PARITY_EN
  ,
  output logic             PERR
`endif
);

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

  // ---------------------------------------------------------------------------
  // Shifter state
  // ---------------------------------------------------------------------------
  logic [FRAME-1:0] shift_q;
  logic [FRAME-1:0] shift_next;
  logic [CNT_W-1:0] cnt_q;
  logic             frame_done;

  // Frame word as it will look after the current edge's bit is shifted in.
  // On the completing edge, this is the full frame. The output buffer can
  // therefore load the word on the same edge as the last bit.
  generate
    if (MSB_FIRST != 0) begin : g_msb_first
      assign shift_next = {shift_q[FRAME-2:0], SIN};
    end else begin : g_lsb_first
      assign shift_next = {SIN, shift_q[FRAME-1:1]};
    end
  endgenerate

  assign frame_done = EN && (cnt_q == LAST_CNT);

  // ---------------------------------------------------------------------------
  // Split the completed frame into data and (optionally) the parity bit.
  // With MSB_FIRST, the trailing parity bit is the newest bit, so it ends up
  // in bit 0. With LSB-first, it ends up in the top bit.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] frame_word;

`ifdef PARITY_EN
  logic             frame_par;
  logic             frame_perr;

  generate
    if (MSB_FIRST != 0) begin : g_msb_split
      assign frame_word = shift_next[FRAME-1:1];
      assign frame_par  = shift_next[0];
    end else begin : g_lsb_split
      assign frame_word = shift_next[WIDTH-1:0];
      assign frame_par  = shift_next[FRAME-1];
    end
  endgenerate

  // Even parity: data bits plus the parity bit must XOR to zero.
  assign frame_perr = (^frame_word) ^ frame_par;
`else
  assign frame_word = shift_next;
`endif

  // ---------------------------------------------------------------------------
  // Shifter: bit counter and shift register.
  // A reset or clear part-way through a frame discards the partial word.
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge
  // values; blocking here would make results depend on statement order.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (!SCLRn) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (EN) begin
      shift_q <= shift_next;
      cnt_q   <= frame_done ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Output buffer FSM: one word of storage behind the shifter.
  //   EMPTY + done              -> FULL, load word
  //   FULL  + READY + done      -> FULL, load word (drain and refill)
  //   FULL  + !READY + done     -> FULL, drop word, raise OVF
  //   FULL  + READY + !done     -> EMPTY, DOUT holds its last value
  // ---------------------------------------------------------------------------
  buf_state_e       state_q;
  logic [WIDTH-1:0] dout_q;
  logic             ovf_q;
  logic             load_word;

  // The buffer can accept a new word when it is empty or is being drained on
  // this edge.
  assign load_word = frame_done && ((state_q == BUF_EMPTY) || READY);

`ifdef PARITY_EN
  logic perr_q;
`endif

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= BUF_EMPTY;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else if (!SCLRn) begin
      state_q <= BUF_EMPTY;
      dout_q  <= '0;
      ovf_q   <= 1'b0;
`ifdef PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      case (state_q)
        BUF_EMPTY: begin
          if (frame_done) begin
            state_q <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (frame_done && !READY) begin
            ovf_q <= 1'b1;
          end else if (!frame_done && READY) begin
            state_q <= BUF_EMPTY;
          end
        end
        default: state_q <= BUF_EMPTY;
      endcase

      if (load_word) begin
        dout_q <= frame_word;
`ifdef PARITY_EN
        perr_q <= frame_perr;
`endif
      end
    end
  end

  // All outputs come straight from flops.
  assign DOUT   = dout_q;
  assign VALID  = (state_q == BUF_FULL);
  assign OVF    = ovf_q;
  assign BITCNT = cnt_q;
`ifdef PARITY_EN
  assign PERR   = perr_q;
`endif

endmodule
